// File: rtl/alu_cmd_queue.sv
// In-order command buffer between a command producer and the registered ALU stage.
// Holds up to DEPTH (operand1, operand2, operation) entries behind valid/ready handshakes.
module alu_cmd_queue #(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N-1:0]               in_operand1,
   input  logic [N-1:0]               in_operand2,
   input  logic [1:0]                 in_operation,
   input  logic                       flush,
   input  logic                       alu_ready,
   output logic                       issue_valid,
   output logic [N-1:0]               operand1,
   output logic [N-1:0]               operand2,
   output logic [1:0]                 operation,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [N-1:0]  mem_op1 [DEPTH];
   logic [N-1:0]  mem_op2 [DEPTH];
   logic [1:0]    mem_opc [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push;
   logic          pop;

   // in_ready comes only from registered count, so a pop at full frees space a cycle later
   assign in_ready    = (count < FULL);
   assign issue_valid = (count != '0);
   assign push        = in_valid && in_ready;
   assign pop         = issue_valid && alu_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem_op1[wr_ptr] <= in_operand1;
         mem_op2[wr_ptr] <= in_operand2;
         mem_opc[wr_ptr] <= in_operation;
      end
   end

   always_comb begin
      operand1  = '0;
      operand2  = '0;
      operation = '0;
      if (issue_valid) begin
         operand1  = mem_op1[rd_ptr];
         operand2  = mem_op2[rd_ptr];
         operation = mem_opc[rd_ptr];
      end
   end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed self-checking bench for alu_cmd_queue (N=4, DEPTH=4).
module tb_alu_cmd_queue;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_operand1 = '0;
   logic [3:0] in_operand2 = '0;
   logic [1:0] in_operation = '0;
   logic       flush = 1'b0;
   logic       alu_ready = 1'b0;
   logic       issue_valid;
   logic [3:0] operand1;
   logic [3:0] operand2;
   logic [1:0] operation;
   logic [2:0] count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   alu_cmd_queue #(.N(4), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_operand1  (in_operand1),
      .in_operand2  (in_operand2),
      .in_operation (in_operation),
      .flush        (flush),
      .alu_ready    (alu_ready),
      .issue_valid  (issue_valid),
      .operand1     (operand1),
      .operand2     (operand2),
      .operation    (operation),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      in_valid     = v;
      in_operand1  = a;
      in_operand2  = b;
      in_operation = op;
   endtask

   task automatic check_head(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      check({tag, ".valid"}, 32'(issue_valid), 32'd1);
      check({tag, ".op1"}, 32'(operand1), 32'(a));
      check({tag, ".op2"}, 32'(operand2), 32'(b));
      check({tag, ".opc"}, 32'(operation), 32'(op));
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".count"}, 32'(count), 32'd0);
      check({tag, ".valid"}, 32'(issue_valid), 32'd0);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".op1"}, 32'(operand1), 32'd0);
      check({tag, ".op2"}, 32'(operand2), 32'd0);
      check({tag, ".opc"}, 32'(operation), 32'd0);
   endtask

   logic [9:0] exp_q [$];
   logic [9:0] e;

   initial begin
      // reset then idle
      repeat (2) tick();
      reset = 1'b0;
      check_empty("reset");
      tick();
      check_empty("idle");

      // single command with hold
      drive(1'b1, 4'd3, 4'd5, 2'b01);
      tick();
      drive(1'b0, '0, '0, '0);
      check_head("single", 4'd3, 4'd5, 2'b01);
      check("single.count", 32'(count), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_head("hold", 4'd3, 4'd5, 2'b01);
      end
      alu_ready = 1'b1;
      tick();
      alu_ready = 1'b0;
      check("single_pop.count", 32'(count), 32'd0);
      check("single_pop.valid", 32'(issue_valid), 32'd0);

      // fill to DEPTH, fifth push held off
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i + 1), 4'(i + 1), 2'(i));
         tick();
      end
      check("full.count", 32'(count), 32'd4);
      check("full.in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 4'd5, 4'd5, 2'b00);
      tick();
      check("held.count", 32'(count), 32'd4);
      check_head("held.head", 4'd1, 4'd1, 2'b00);
      alu_ready = 1'b1;
      tick();
      check("pop1.in_ready", 32'(in_ready), 32'd1);
      check("pop1.count", 32'(count), 32'd3);
      check_head("pop1.head", 4'd2, 4'd2, 2'b01);
      tick();
      drive(1'b0, '0, '0, '0);
      check("pop2.count", 32'(count), 32'd3);
      check_head("pop2.head", 4'd3, 4'd3, 2'b10);
      tick();
      check_head("pop3.head", 4'd4, 4'd4, 2'b11);
      tick();
      check_head("pop4.head", 4'd5, 4'd5, 2'b00);
      tick();
      alu_ready = 1'b0;
      check("drain.count", 32'(count), 32'd0);

      // steady push+pop at count=2, wrapping pointers
      for (int k = 0; k < 2; k++) begin
         e = {4'(k + 10), 4'(~(k + 10)), 2'(k)};
         exp_q.push_back(e);
         drive(1'b1, e[9:6], e[5:2], e[1:0]);
         tick();
      end
      check("pp.count0", 32'(count), 32'd2);
      alu_ready = 1'b1;
      for (int k = 2; k < 12; k++) begin
         e = {4'(k + 10), 4'(~(k + 10)), 2'(k)};
         exp_q.push_back(e);
         drive(1'b1, e[9:6], e[5:2], e[1:0]);
         check_head("pp.head", exp_q[0][9:6], exp_q[0][5:2], exp_q[0][1:0]);
         void'(exp_q.pop_front());
         tick();
         check("pp.count", 32'(count), 32'd2);
      end
      drive(1'b0, '0, '0, '0);
      while (exp_q.size() > 0) begin
         check_head("pp.drain", exp_q[0][9:6], exp_q[0][5:2], exp_q[0][1:0]);
         void'(exp_q.pop_front());
         tick();
      end
      alu_ready = 1'b0;
      check("pp.end_count", 32'(count), 32'd0);

      // flush with concurrent push
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), 4'd0, 2'b11);
         tick();
      end
      flush = 1'b1;
      drive(1'b1, 4'd7, 4'd7, 2'b10);
      check("flush.in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      check_empty("flush");
      drive(1'b1, 4'd9, 4'd1, 2'b00);
      tick();
      drive(1'b0, '0, '0, '0);
      check_head("after_flush", 4'd9, 4'd1, 2'b00);
      check("after_flush.count", 32'(count), 32'd1);
      alu_ready = 1'b1;
      tick();
      alu_ready = 1'b0;
      check("after_flush.pop", 32'(count), 32'd0);

      // reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 12), 4'(i + 1), 2'b01);
         tick();
      end
      drive(1'b0, '0, '0, '0);
      check("pre_rst.count", 32'(count), 32'd3);
      alu_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_empty("mid_reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst.valid", 32'(issue_valid), 32'd0);
      end
      alu_ready = 1'b0;
      drive(1'b1, 4'd6, 4'd2, 2'b11);
      tick();
      drive(1'b0, '0, '0, '0);
      check_head("post_rst.first", 4'd6, 4'd2, 2'b11);
      check("post_rst.count", 32'(count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
